// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache that sits
// between the MEM pipeline stage and a multi-cycle, full-line main memory.
// Optional feature macro: DCACHE_STATS_EN adds hit_cnt_o / miss_cnt_o counters.
//
// Memory-side handshake: mem_req_o rises with a stable mem_addr_o/mem_write_o
// (and mem_wdata_o for write-backs) and holds until the single-cycle mem_ack_i
// pulse; the transfer completes on the edge that samples mem_ack_i=1 while
// mem_req_o=1. An ack seen while mem_req_o=0 is ignored.
module dcache_ctrl #(
    parameter int LINES     = 32,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_read_i,
    input  logic                 cpu_write_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i,
`ifdef DCACHE_STATS_EN
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o,
`endif
    output logic [1:0]           dbg_state_o
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - 5 - IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t                 state_q;
    logic [TAG_W-1:0]       tag_arr  [LINES];
    logic [LINE_BITS-1:0]   data_arr [LINES];
    logic [LINES-1:0]       valid_q;
    logic [LINES-1:0]       dirty_q;
    logic [IDX_W-1:0]       pend_idx_q;
    logic [TAG_W-1:0]       pend_tag_q;

    logic [IDX_W-1:0]       idx;
    logic [TAG_W-1:0]       tag;
    logic [2:0]             word_sel;
    logic [LINE_BITS-1:0]   cur_line;
    logic                   access;
    logic                   idle;
    logic                   hit;
    logic                   fill_done;
    logic                   unused_addr_lsb;

    assign idx             = cpu_addr_i[5 +: IDX_W];
    assign tag             = cpu_addr_i[31 -: TAG_W];
    assign word_sel        = cpu_addr_i[4:2];
    assign unused_addr_lsb = ^cpu_addr_i[1:0];
    assign cur_line        = data_arr[idx];
    assign access          = cpu_read_i | cpu_write_i;
    assign idle            = (state_q == IDLE);
    assign hit             = valid_q[idx] && (tag_arr[idx] == tag);
    assign fill_done       = (state_q == FILL) && mem_req_o && mem_ack_i;
    assign dbg_state_o     = state_q;

    // Zero-latency hit path: load data and stall are resolved in the access cycle.
    always_comb begin
        cpu_rdata_o = '0;
        if (idle && cpu_read_i && hit) begin
            cpu_rdata_o = cur_line[{word_sel, 5'b0} +: 32];
        end
        cpu_stall_o = !(idle && (!access || hit));
    end

    // Tag/data arrays: line install on fill completion, word merge on a store hit.
    // Not reset; a reset edge also blocks any install so a partial miss is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (fill_done) begin
                data_arr[pend_idx_q] <= mem_rdata_i;
                tag_arr[pend_idx_q]  <= pend_tag_q;
            end else if (idle && cpu_write_i && hit) begin
                data_arr[idx][{word_sel, 5'b0} +: 32] <= cpu_wdata_i;
            end
        end
    end

    // Miss FSM with registered memory-side request outputs and valid/dirty bits.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_req_o   <= 1'b0;
            mem_write_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            pend_idx_q  <= '0;
            pend_tag_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access && hit) begin
                        if (cpu_write_i) begin
                            dirty_q[idx] <= 1'b1;
                        end
                    end else if (access) begin
                        pend_idx_q <= idx;
                        pend_tag_q <= tag;
                        mem_req_o  <= 1'b1;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q     <= WB;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {tag_arr[idx], idx, 5'b0};
                            mem_wdata_o <= cur_line;
                        end else begin
                            state_q     <= FILL;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= {tag, idx, 5'b0};
                        end
                    end
                end
                WB: begin
                    // Request stays up: the fill follows directly on the next cycle.
                    if (mem_ack_i) begin
                        dirty_q[pend_idx_q] <= 1'b0;
                        state_q             <= FILL;
                        mem_write_o         <= 1'b0;
                        mem_addr_o          <= {pend_tag_q, pend_idx_q, 5'b0};
                    end
                end
                FILL: begin
                    if (mem_ack_i) begin
                        valid_q[pend_idx_q] <= 1'b1;
                        dirty_q[pend_idx_q] <= 1'b0;
                        state_q             <= IDLE;
                        mem_req_o           <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic refill_q;

    // Hit/miss counters; the hit that follows a completed fill is the same
    // access re-resolving, so it is not counted again.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            refill_q   <= 1'b0;
        end else begin
            if (fill_done) begin
                refill_q <= 1'b1;
            end else if (idle) begin
                refill_q <= 1'b0;
            end
            if (idle && access) begin
                if (hit) begin
                    if (!refill_q) begin
                        hit_cnt_o <= hit_cnt_o + 32'd1;
                    end
                end else begin
                    miss_cnt_o <= miss_cnt_o + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed, table-driven and randomized checks for dcache_ctrl.
module tb_dcache_ctrl;

    localparam int LB = 256;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          cpu_read_i = 1'b0;
    logic          cpu_write_i = 1'b0;
    logic [31:0]   cpu_addr_i = '0;
    logic [31:0]   cpu_wdata_i = '0;
    logic [31:0]   cpu_rdata_o;
    logic          cpu_stall_o;
    logic          mem_req_o;
    logic          mem_write_o;
    logic [31:0]   mem_addr_o;
    logic [LB-1:0] mem_wdata_o;
    logic [LB-1:0] mem_rdata_i = '0;
    logic          mem_ack_i = 1'b0;
    logic [1:0]    dbg_state_o;
`ifdef DCACHE_STATS_EN
    logic [31:0]   hit_cnt_o;
    logic [31:0]   miss_cnt_o;
`endif

    dcache_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_read_i  (cpu_read_i),
        .cpu_write_i (cpu_write_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
`ifdef DCACHE_STATS_EN
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o),
`endif
        .dbg_state_o (dbg_state_o)
    );

    // clock
    always #5 clk_i = ~clk_i;

    // ---------------- bookkeeping ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- main memory model ----------------
    logic [LB-1:0] mem_model [int unsigned];
    int  lat      = 2;
    int  cnt      = 0;
    bit  resp_en  = 1'b1;
    int  txn_cnt  = 0;
    int  wb_cnt   = 0;
    int  fill_cnt = 0;
    bit  saw_write = 1'b0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'd2654435761) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [LB-1:0] line_of(input logic [31:0] a);
        logic [LB-1:0] l;
        logic [31:0]   base;
        int unsigned   key;
        key = int'(a >> 5);
        if (mem_model.exists(key)) return mem_model[key];
        base = {a[31:5], 5'b0};
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = pat(base + 32'(w * 4));
        return l;
    endfunction

    // Advance one clock; runs the memory responder #1 after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
        if (mem_write_o) saw_write = 1'b1;
        if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            cnt = 0;
        end else if (!mem_req_o) begin
            cnt = 0;
        end else if (resp_en) begin
            if (cnt >= lat) begin
                mem_ack_i = 1'b1;
                txn_cnt++;
                if (mem_write_o) begin
                    mem_model[int'(mem_addr_o >> 5)] = mem_wdata_o;
                    wb_cnt++;
                end else begin
                    mem_rdata_i = line_of(mem_addr_o);
                    fill_cnt++;
                end
            end else begin
                cnt++;
            end
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        cpu_read_i = 1'b0;
        cpu_write_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
    endtask

    // Wait (bounded) for the stall to drop; an expired bound counts as a failure.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (cpu_stall_o && n < 400) begin
            step();
            n++;
        end
        if (cpu_stall_o) begin
            n_chk++;
            $display("FAIL %s: stall still 1 after %0d cycles, required 0", name, n);
        end
    endtask

    // One complete CPU access: returns whether it stalled on its first cycle
    // and the load data seen when the stall dropped.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, output bit was_miss,
                             output logic [31:0] rdata);
        cpu_read_i  = rd;
        cpu_write_i = wr;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        #1;
        was_miss = cpu_stall_o;
        wait_ready("access_wait");
        rdata = cpu_rdata_o;
        step();
        cpu_read_i  = 1'b0;
        cpu_write_i = 1'b0;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_miss;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    // reference cache occupancy for random phase (indices 0..7 only)
    int          r_tag   [8];
    bit          r_valid [8];
    bit          r_dirty [8];
    logic [31:0] ref_mem [int unsigned];

    initial begin
        bit          miss;
        logic [31:0] rd;
        int          t0, w0, f0;
        bit          hold_ok;
        int          exp_wb, exp_txn;

        // init memory: line 0x100 carries 0xDEADBEEF in word 0
        begin
            logic [LB-1:0] l;
            l = line_of(32'h100);
            l[31:0] = 32'hDEAD_BEEF;
            mem_model[int'(32'h100 >> 5)] = l;
        end

        // ---------- reset state ----------
        do_reset();
        chk("rst_req",   LB'(mem_req_o),   '0);
        chk("rst_write", LB'(mem_write_o), '0);
        chk("rst_addr",  LB'(mem_addr_o),  '0);
        chk("rst_wdata", mem_wdata_o,      '0);
        chk("rst_stall", LB'(cpu_stall_o), '0);
        chk("rst_rdata", LB'(cpu_rdata_o), '0);

        // ---------- 1: cold load miss + fill ----------
        lat = 2;
        cpu_read_i = 1'b1;
        cpu_addr_i = 32'h100;
        #1;
        chk("t1_stall_same_cycle", LB'(cpu_stall_o), 1);
        step();
        chk("t1_fill_req",   LB'(mem_req_o),   1);
        chk("t1_fill_write", LB'(mem_write_o), 0);
        chk("t1_fill_addr",  LB'(mem_addr_o),  32'h100);
        wait_ready("t1_wait");
        chk("t1_rdata",        LB'(cpu_rdata_o), 32'hDEAD_BEEF);
        chk("t1_req_dropped",  LB'(mem_req_o),   0);
        step();
        cpu_read_i = 1'b0;

        // ---------- 2: store hit, then load-after-store ----------
        t0 = txn_cnt;
        cpu_write_i = 1'b1;
        cpu_addr_i  = 32'h104;
        cpu_wdata_i = 32'h1234_5678;
        #1;
        chk("t2_store_stall", LB'(cpu_stall_o), 0);
        step();
        cpu_write_i = 1'b0;
        cpu_read_i  = 1'b1;
        #1;
        chk("t2_load_stall", LB'(cpu_stall_o), 0);
        chk("t2_load_rdata", LB'(cpu_rdata_o), 32'h1234_5678);
        chk("t2_no_req",     LB'(mem_req_o),   0);
        step();
        cpu_read_i = 1'b0;
        chk("t2_no_txn", LB'(txn_cnt - t0), 0);

        // ---------- 3: dirty conflict -> write-back then fill ----------
        t0 = txn_cnt; w0 = wb_cnt; f0 = fill_cnt;
        cpu_read_i = 1'b1;
        cpu_addr_i = 32'h500;
        #1;
        chk("t3_stall", LB'(cpu_stall_o), 1);
        step();
        chk("t3_wb_req",   LB'(mem_req_o),   1);
        chk("t3_wb_write", LB'(mem_write_o), 1);
        chk("t3_wb_addr",  LB'(mem_addr_o),  32'h100);
        chk("t3_wb_word1", LB'(mem_wdata_o[63:32]), 32'h1234_5678);
        chk("t3_wb_word0", LB'(mem_wdata_o[31:0]),  32'hDEAD_BEEF);
        wait_ready("t3_wait");
        chk("t3_rdata", LB'(cpu_rdata_o), pat(32'h500));
        chk("t3_txns",  LB'(txn_cnt - t0), 2);
        chk("t3_wbs",   LB'(wb_cnt - w0), 1);
        chk("t3_fills", LB'(fill_cnt - f0), 1);
        step();
        cpu_read_i = 1'b0;

        // ---------- 4: clean conflict -> fill only, sees written-back data ----------
        saw_write = 1'b0;
        w0 = wb_cnt; f0 = fill_cnt;
        do_access(1'b1, 1'b0, 32'h104, 32'h0, miss, rd);
        chk("t4_miss",      LB'(miss), 1);
        chk("t4_rdata",     LB'(rd), 32'h1234_5678);
        chk("t4_no_write",  LB'(saw_write), 0);
        chk("t4_wbs",       LB'(wb_cnt - w0), 0);
        chk("t4_fills",     LB'(fill_cnt - f0), 1);

        // ---------- 5: long memory stall, then reset mid-fill ----------
        resp_en = 1'b0;
        cpu_read_i = 1'b1;
        cpu_addr_i = 32'h900;
        #1;
        chk("t5_stall", LB'(cpu_stall_o), 1);
        step();
        chk("t5_req",   LB'(mem_req_o),   1);
        chk("t5_write", LB'(mem_write_o), 0);
        chk("t5_addr",  LB'(mem_addr_o),  32'h900);
        hold_ok = 1'b1;
        repeat (20) begin
            step();
            if (!(cpu_stall_o && mem_req_o && mem_addr_o == 32'h900)) hold_ok = 1'b0;
        end
        chk("t5_hold_stable", LB'(hold_ok), 1);
        rst_i = 1'b0;
        cpu_read_i = 1'b0;
        step();
        chk("t5_req_after_rst",   LB'(mem_req_o),   0);
        chk("t5_stall_after_rst", LB'(cpu_stall_o), 0);
        rst_i = 1'b1;
        mem_rdata_i = '1;
        mem_ack_i = 1'b1;
        step();
        chk("t5_late_ack_ignored", LB'(mem_req_o), 0);
        resp_en = 1'b1;
        do_access(1'b1, 1'b0, 32'h900, 32'h0, miss, rd);
        chk("t5_reload_miss",  LB'(miss), 1);
        chk("t5_reload_rdata", LB'(rd), pat(32'h900));

        // ---------- 6: statistics counters ----------
        do_reset();
        do_access(1'b1, 1'b0, 32'hD00, 32'h0, miss, rd);
        chk("t6_first_miss", LB'(miss), 1);
        for (int i = 1; i < 4; i++) begin
            do_access(1'b1, 1'b0, 32'hD00 + 32'(i * 4), 32'h0, miss, rd);
            chk("t6_hit", LB'(miss), 0);
        end
`ifdef DCACHE_STATS_EN
        chk("t6_miss_cnt", LB'(miss_cnt_o), 1);
        chk("t6_hit_cnt",  LB'(hit_cnt_o),  3);
`endif

        // ---------- table-driven vectors ----------
        vecs[0] = '{1'b1, 1'b0, 32'hC20, 32'h0,         1'b1, pat(32'hC20)};
        vecs[1] = '{1'b1, 1'b0, 32'hC3C, 32'h0,         1'b0, pat(32'hC3C)};
        vecs[2] = '{1'b0, 1'b1, 32'hC24, 32'hAAAA_0001, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'hC24, 32'h0,         1'b0, 32'hAAAA_0001};
        vecs[4] = '{1'b1, 1'b0, 32'h820, 32'h0,         1'b1, pat(32'h820)};
        vecs[5] = '{1'b1, 1'b0, 32'hC24, 32'h0,         1'b1, 32'hAAAA_0001};
        vecs[6] = '{1'b0, 1'b1, 32'hC28, 32'h5555_0002, 1'b0, 32'h0};
        do_reset();
        lat = 1;
        for (int i = 0; i < 7; i++) begin
            do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, miss, rd);
            chk($sformatf("vec%0d_miss", i), LB'(miss), LB'(vecs[i].exp_miss));
            if (vecs[i].rd) chk($sformatf("vec%0d_rdata", i), LB'(rd), LB'(vecs[i].exp_rdata));
        end

        // ---------- randomized against reference model ----------
        do_reset();
        for (int i = 0; i < 8; i++) begin
            r_valid[i] = 1'b0;
            r_dirty[i] = 1'b0;
            r_tag[i]   = 0;
        end
        t0 = txn_cnt; w0 = wb_cnt;
        exp_wb = 0; exp_txn = 0;
        for (int n = 0; n < 300; n++) begin
            int          ti, ii, wi;
            bit          is_wr, exp_hit;
            logic [31:0] a, wd, exp_rd;
            ti = int'($urandom_range(4, 7));
            ii = int'($urandom_range(0, 7));
            wi = int'($urandom_range(0, 7));
            is_wr = bit'($urandom_range(0, 1));
            wd = $urandom;
            lat = int'($urandom_range(0, 3));
            a = 32'(ti * 1024 + ii * 32 + wi * 4);
            exp_hit = r_valid[ii] && (r_tag[ii] == ti);
            if (!exp_hit) begin
                exp_txn++;
                if (r_valid[ii] && r_dirty[ii]) begin
                    exp_wb++;
                    exp_txn++;
                end
            end
            exp_rd = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
            do_access(!is_wr, is_wr, a, wd, miss, rd);
            chk("rnd_miss", LB'(miss), LB'(!exp_hit));
            if (!is_wr) chk("rnd_rdata", LB'(rd), LB'(exp_rd));
            if (!exp_hit) r_dirty[ii] = 1'b0;
            r_valid[ii] = 1'b1;
            r_tag[ii]   = ti;
            if (is_wr) begin
                r_dirty[ii] = 1'b1;
                ref_mem[int'(a)] = wd;
            end
        end
        chk("rnd_wb_count",  LB'(wb_cnt - w0),  LB'(exp_wb));
        chk("rnd_txn_count", LB'(txn_cnt - t0), LB'(exp_txn));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
